// File: rtl/regfile_pkg.sv
// Shared types and constants for the 16 x 16-bit general register file.
package regfile_pkg;

    localparam int WIDTH = 16;
    localparam int NREG  = 16;

    typedef logic [3:0]       reg_idx_t;
    typedef logic [WIDTH-1:0] word_t;

    localparam reg_idx_t ZERO_IDX = 4'd0;

endpackage : regfile_pkg

// File: rtl/reg_decoder4to16.sv
// One-hot decoder: a 4-bit register index plus enable gives a 16-bit select mask.
module reg_decoder4to16
    import regfile_pkg::*;
(
    input  reg_idx_t          idx_i,
    input  logic              en_i,
    output logic [NREG-1:0]   onehot_o
);

    // Index-to-one-hot decode, all zeros when disabled
    always_comb begin
        onehot_o = {NREG{1'b0}};
        if (en_i) begin
            onehot_o[idx_i] = 1'b1;
        end else begin
            onehot_o = {NREG{1'b0}};
        end
    end

endmodule : reg_decoder4to16

// File: rtl/reg_bank_writer.sv
// Write side of the general register file: register storage, write-back decode
// and a per-register busy scoreboard that stalls issue on write-after-write.
module reg_bank_writer
    import regfile_pkg::*;
#(
    parameter int WIDTH    = regfile_pkg::WIDTH,
    parameter int NREG     = regfile_pkg::NREG,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             iss_valid,
    input  logic [3:0]       iss_rd,
    output logic             iss_ready,
    input  logic             wb_valid,
    input  logic [3:0]       wb_rd,
    input  logic [WIDTH-1:0] wb_data,
    output logic             wb_stray,
    output logic [NREG-1:0]  busy,
    output logic [4:0]       pend_cnt,
    output logic [WIDTH-1:0] ra,
    output logic [WIDTH-1:0] rb,
    output logic [WIDTH-1:0] rc,
    output logic [WIDTH-1:0] rd,
    output logic [WIDTH-1:0] re,
    output logic [WIDTH-1:0] rf,
    output logic [WIDTH-1:0] rg,
    output logic [WIDTH-1:0] rh,
    output logic [WIDTH-1:0] ri,
    output logic [WIDTH-1:0] rj,
    output logic [WIDTH-1:0] rk,
    output logic [WIDTH-1:0] rl,
    output logic [WIDTH-1:0] rm,
    output logic [WIDTH-1:0] rn,
    output logic [WIDTH-1:0] ro,
    output logic [WIDTH-1:0] rp
);

    // Register 0 is masked out of every set/load when it is hardwired to zero.
    localparam logic [NREG-1:0] KEEP_MASK = ZERO_REG ? ~(NREG'(1)) : {NREG{1'b1}};

    logic [WIDTH-1:0] regs_q [NREG];
    logic [NREG-1:0]  busy_q, busy_d;
    logic [4:0]       pend_cnt_q, pend_cnt_d;
    logic             wb_stray_q, wb_stray_d;

    logic             iss_ready_s;
    logic             iss_fire_s;
    logic [NREG-1:0]  set_mask_s;
    logic [NREG-1:0]  wb_mask_s;
    logic [NREG-1:0]  set_eff_s;
    logic [NREG-1:0]  ld_eff_s;
    logic [NREG-1:0]  clr_s;

    // Issue readiness looks only at the registered scoreboard, never at a same-cycle write-back
    always_comb begin
        iss_ready_s = 1'b0;
        if (ZERO_REG && (iss_rd == ZERO_IDX)) begin
            iss_ready_s = 1'b1;
        end else begin
            iss_ready_s = ~busy_q[iss_rd];
        end
    end

    assign iss_fire_s = iss_valid & iss_ready_s;

    reg_decoder4to16 u_iss_dec (
        .idx_i    (iss_rd),
        .en_i     (iss_fire_s),
        .onehot_o (set_mask_s)
    );

    reg_decoder4to16 u_wb_dec (
        .idx_i    (wb_rd),
        .en_i     (wb_valid),
        .onehot_o (wb_mask_s)
    );

    assign set_eff_s = set_mask_s & KEEP_MASK;
    assign ld_eff_s  = wb_mask_s & KEEP_MASK;
    assign clr_s     = ld_eff_s & busy_q;

    // Scoreboard next state: set wins over clear; count tracks the net change
    always_comb begin
        busy_d     = (busy_q & ~clr_s) | set_eff_s;
        wb_stray_d = |(ld_eff_s & ~busy_q);
        pend_cnt_d = pend_cnt_q;
        case ({|set_eff_s, |clr_s})
            2'b10:   pend_cnt_d = pend_cnt_q + 5'd1;
            2'b01:   pend_cnt_d = pend_cnt_q - 5'd1;
            default: pend_cnt_d = pend_cnt_q;
        endcase
    end

    // Scoreboard, pending count and stray flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q     <= {NREG{1'b0}};
            pend_cnt_q <= 5'd0;
            wb_stray_q <= 1'b0;
        end else begin
            busy_q     <= busy_d;
            pend_cnt_q <= pend_cnt_d;
            wb_stray_q <= wb_stray_d;
        end
    end

    // Architectural register array, loaded by the write-back decode
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 0; n < NREG; n++) begin
                regs_q[n] <= {WIDTH{1'b0}};
            end
        end else begin
            for (int n = 0; n < NREG; n++) begin
                if (ld_eff_s[n]) begin
                    regs_q[n] <= wb_data;
                end
            end
        end
    end

    assign iss_ready = iss_ready_s;
    assign busy      = busy_q;
    assign pend_cnt  = pend_cnt_q;
    assign wb_stray  = wb_stray_q;

    assign ra = regs_q[0];
    assign rb = regs_q[1];
    assign rc = regs_q[2];
    assign rd = regs_q[3];
    assign re = regs_q[4];
    assign rf = regs_q[5];
    assign rg = regs_q[6];
    assign rh = regs_q[7];
    assign ri = regs_q[8];
    assign rj = regs_q[9];
    assign rk = regs_q[10];
    assign rl = regs_q[11];
    assign rm = regs_q[12];
    assign rn = regs_q[13];
    assign ro = regs_q[14];
    assign rp = regs_q[15];

endmodule : reg_bank_writer

// File: tb/tb_reg_bank_writer.sv
// Self-checking bench for reg_bank_writer: directed vector table plus
// fill/drain, saturation (ZERO_REG = 0) and mid-operation reset sequences.
module tb_reg_bank_writer;

    logic clk;
    logic rst_n;

    logic        iss_valid, wb_valid, iss_ready, wb_stray;
    logic [3:0]  iss_rd, wb_rd;
    logic [15:0] wb_data, busy;
    logic [4:0]  pend_cnt;
    logic [15:0][15:0] rv;

    logic        z_iss_valid, z_wb_valid, z_iss_ready, z_wb_stray;
    logic [3:0]  z_iss_rd, z_wb_rd;
    logic [15:0] z_wb_data, z_busy;
    logic [4:0]  z_pend_cnt;
    logic [15:0][15:0] zv;

    int n_checks;
    int n_fail;

    reg_bank_writer #(.WIDTH(16), .NREG(16), .ZERO_REG(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .wb_stray(wb_stray), .busy(busy), .pend_cnt(pend_cnt),
        .ra(rv[0]), .rb(rv[1]), .rc(rv[2]), .rd(rv[3]),
        .re(rv[4]), .rf(rv[5]), .rg(rv[6]), .rh(rv[7]),
        .ri(rv[8]), .rj(rv[9]), .rk(rv[10]), .rl(rv[11]),
        .rm(rv[12]), .rn(rv[13]), .ro(rv[14]), .rp(rv[15])
    );

    reg_bank_writer #(.WIDTH(16), .NREG(16), .ZERO_REG(1'b0)) dut_nz (
        .clk(clk), .rst_n(rst_n),
        .iss_valid(z_iss_valid), .iss_rd(z_iss_rd), .iss_ready(z_iss_ready),
        .wb_valid(z_wb_valid), .wb_rd(z_wb_rd), .wb_data(z_wb_data),
        .wb_stray(z_wb_stray), .busy(z_busy), .pend_cnt(z_pend_cnt),
        .ra(zv[0]), .rb(zv[1]), .rc(zv[2]), .rd(zv[3]),
        .re(zv[4]), .rf(zv[5]), .rg(zv[6]), .rh(zv[7]),
        .ri(zv[8]), .rj(zv[9]), .rk(zv[10]), .rl(zv[11]),
        .rm(zv[12]), .rn(zv[13]), .ro(zv[14]), .rp(zv[15])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [3:0]  ird;
        logic        wv;
        logic [3:0]  wrd;
        logic [15:0] wd;
        logic        exp_rdy;
        logic [15:0] exp_busy;
        logic [4:0]  exp_cnt;
        logic        exp_stray;
        int          chk_reg;
        logic [15:0] exp_reg;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_post(input string name, input logic [15:0] eb, input logic [4:0] ec, input logic es);
        check({name, " busy"}, 32'(busy), 32'(eb));
        check({name, " pend_cnt"}, 32'(pend_cnt), 32'(ec));
        check({name, " stray"}, 32'(wb_stray), 32'(es));
        check({name, " popcount"}, 32'(pend_cnt), 32'($countones(busy)));
    endtask

    task automatic idle_inputs();
        iss_valid = 1'b0; iss_rd = 4'd0; wb_valid = 1'b0; wb_rd = 4'd0; wb_data = 16'h0000;
        z_iss_valid = 1'b0; z_iss_rd = 4'd0; z_wb_valid = 1'b0; z_wb_rd = 4'd0; z_wb_data = 16'h0000;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        //            iv    ird   wv    wrd   wd        rdy   busy      cnt   stray reg data
        vecs[0]  = '{1'b0, 4'd0, 1'b1, 4'd5, 16'hBEEF, 1'b1, 16'h0000, 5'd0, 1'b1, 5, 16'hBEEF};
        vecs[1]  = '{1'b0, 4'd0, 1'b0, 4'd0, 16'h0000, 1'b1, 16'h0000, 5'd0, 1'b0, 4, 16'h0000};
        vecs[2]  = '{1'b1, 4'd3, 1'b0, 4'd0, 16'h0000, 1'b1, 16'h0008, 5'd1, 1'b0, 3, 16'h0000};
        vecs[3]  = '{1'b1, 4'd3, 1'b0, 4'd0, 16'h0000, 1'b0, 16'h0008, 5'd1, 1'b0, 5, 16'hBEEF};
        vecs[4]  = '{1'b1, 4'd3, 1'b1, 4'd3, 16'h1234, 1'b0, 16'h0000, 5'd0, 1'b0, 3, 16'h1234};
        vecs[5]  = '{1'b1, 4'd3, 1'b0, 4'd0, 16'h0000, 1'b1, 16'h0008, 5'd1, 1'b0, 3, 16'h1234};
        vecs[6]  = '{1'b1, 4'd0, 1'b0, 4'd0, 16'h0000, 1'b1, 16'h0008, 5'd1, 1'b0, 0, 16'h0000};
        vecs[7]  = '{1'b0, 4'd0, 1'b1, 4'd0, 16'hFFFF, 1'b1, 16'h0008, 5'd1, 1'b0, 0, 16'h0000};
        vecs[8]  = '{1'b1, 4'd7, 1'b1, 4'd7, 16'h00A5, 1'b1, 16'h0088, 5'd2, 1'b1, 7, 16'h00A5};
        vecs[9]  = '{1'b1, 4'd2, 1'b1, 4'd7, 16'h1111, 1'b1, 16'h000C, 5'd2, 1'b0, 7, 16'h1111};
        vecs[10] = '{1'b1, 4'd0, 1'b1, 4'd3, 16'h0033, 1'b1, 16'h0004, 5'd1, 1'b0, 3, 16'h0033};
        vecs[11] = '{1'b0, 4'd0, 1'b1, 4'd2, 16'h0022, 1'b1, 16'h0000, 5'd0, 1'b0, 2, 16'h0022};
        vecs[12] = '{1'b0, 4'd0, 1'b0, 4'd0, 16'h0000, 1'b1, 16'h0000, 5'd0, 1'b0, 5, 16'hBEEF};

        rst_n = 1'b0;
        idle_inputs();
        #12;
        check("reset busy", 32'(busy), 32'h0);
        check("reset pend_cnt", 32'(pend_cnt), 32'h0);
        check("reset stray", 32'(wb_stray), 32'h0);
        check("reset rf", 32'(rv[5]), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            iss_valid = vecs[i].iv;  iss_rd = vecs[i].ird;
            wb_valid  = vecs[i].wv;  wb_rd  = vecs[i].wrd; wb_data = vecs[i].wd;
            #1;
            check($sformatf("vec%0d iss_ready", i), 32'(iss_ready), 32'(vecs[i].exp_rdy));
            @(posedge clk);
            #1;
            check_post($sformatf("vec%0d", i), vecs[i].exp_busy, vecs[i].exp_cnt, vecs[i].exp_stray);
            check($sformatf("vec%0d reg%0d", i, vecs[i].chk_reg), 32'(rv[vecs[i].chk_reg]), 32'(vecs[i].exp_reg));
        end

        // Fill registers 1..15, then drain in reverse with each index as data.
        for (int i = 1; i < 16; i++) begin
            @(negedge clk);
            idle_inputs();
            iss_valid = 1'b1; iss_rd = 4'(i);
            #1;
            check($sformatf("fill%0d iss_ready", i), 32'(iss_ready), 32'h1);
            @(posedge clk);
            #1;
            check($sformatf("fill%0d pend_cnt", i), 32'(pend_cnt), 32'(i));
        end
        check("fill busy", 32'(busy), 32'hFFFE);
        for (int i = 15; i >= 1; i--) begin
            @(negedge clk);
            idle_inputs();
            wb_valid = 1'b1; wb_rd = 4'(i); wb_data = 16'(i);
            @(posedge clk);
            #1;
            check($sformatf("drain%0d pend_cnt", i), 32'(pend_cnt), 32'(i - 1));
            check($sformatf("drain%0d stray", i), 32'(wb_stray), 32'h0);
        end
        @(negedge clk);
        idle_inputs();
        @(posedge clk);
        #1;
        check("drain busy", 32'(busy), 32'h0);
        for (int k = 0; k < 16; k++) begin
            check($sformatf("drain reg%0d", k), 32'(rv[k]), 32'(k));
        end

        // Without a hardwired zero register all 16 can be pending.
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            idle_inputs();
            z_iss_valid = 1'b1; z_iss_rd = 4'(i);
            @(posedge clk);
            #1;
            check($sformatf("nz fill%0d pend_cnt", i), 32'(z_pend_cnt), 32'(i + 1));
        end
        check("nz full busy", 32'(z_busy), 32'hFFFF);
        @(negedge clk);
        idle_inputs();
        z_iss_valid = 1'b1; z_iss_rd = 4'd0;
        #1;
        check("nz reg0 iss_ready", 32'(z_iss_ready), 32'h0);
        @(posedge clk);
        #1;
        check("nz hold pend_cnt", 32'(z_pend_cnt), 32'd16);
        @(negedge clk);
        idle_inputs();
        z_wb_valid = 1'b1; z_wb_rd = 4'd0; z_wb_data = 16'h00F0;
        @(posedge clk);
        #1;
        check("nz wb0 ra", 32'(zv[0]), 32'h00F0);
        check("nz wb0 busy", 32'(z_busy), 32'hFFFE);
        check("nz wb0 pend_cnt", 32'(z_pend_cnt), 32'd15);
        check("nz wb0 stray", 32'(z_wb_stray), 32'h0);

        // Reset asserted mid-cycle while state is pending and a stray pulse is live.
        @(negedge clk);
        idle_inputs();
        iss_valid = 1'b1; iss_rd = 4'd4; wb_valid = 1'b1; wb_rd = 4'd9; wb_data = 16'h9999;
        @(posedge clk);
        #1;
        check_post("pre-reset", 16'h0010, 5'd1, 1'b1);
        check("pre-reset rj", 32'(rv[9]), 32'h9999);
        rst_n = 1'b0;
        idle_inputs();
        #1;
        check("async reset busy", 32'(busy), 32'h0);
        check("async reset pend_cnt", 32'(pend_cnt), 32'h0);
        check("async reset stray", 32'(wb_stray), 32'h0);
        check("async reset nz busy", 32'(z_busy), 32'h0);
        for (int k = 0; k < 16; k++) begin
            check($sformatf("async reset reg%0d", k), 32'(rv[k]), 32'h0);
        end
        @(posedge clk);
        #1;
        check("reset held busy", 32'(busy), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_post("post-reset", 16'h0000, 5'd0, 1'b0);
        check("post-reset iss_ready", 32'(iss_ready), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_reg_bank_writer
